// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, one cycle of ALU evaluation in EXEC, and the
// registered result is held in RESP until the granted requester takes it.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             rr;
  logic             gnt;
  logic             sel;
  logic             accept;
  logic             rsp_done;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [OPW-1:0]   op_code;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;

  // Grant selection, handshakes and next state; ready is suppressed while reset is held
  always_comb begin
    state_next = state;
    sel        = 1'b0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~rr;
    end else begin
      sel = req1_valid;
    end
    case (state)
      IDLE: begin
        if ((req0_valid || req1_valid) && rst_n) begin
          accept     = 1'b1;
          req0_ready = ~sel;
          req1_ready = sel;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (gnt ? rsp1_ready : rsp0_ready) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture and grant record on an accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      op_code <= '0;
      gnt     <= 1'b0;
    end else if (accept) begin
      op_a    <= sel ? req1_a  : req0_a;
      op_b    <= sel ? req1_b  : req0_b;
      op_code <= sel ? req1_op : req0_op;
      gnt     <= sel;
    end
  end

  // ALU result and zero flag captured at the end of the EXEC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      zero_q <= 1'b0;
    end else if (state == EXEC) begin
      res_q  <= alu_result;
      zero_q <= alu_zero;
    end
  end

  // Round-robin pointer remembers who was served last; starts at 1 so req0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b1;
    end else if (rsp_done) begin
      rr <= gnt;
    end
  end

  assign alu_a  = op_a;
  assign alu_b  = op_b;
  assign alu_op = op_code;
  assign busy   = (state != IDLE);

  assign rsp0_valid  = (state == RESP) && !gnt;
  assign rsp1_valid  = (state == RESP) && gnt;
  assign rsp0_result = rsp0_valid ? res_q : '0;
  assign rsp1_result = rsp1_valid ? res_q : '0;
  assign rsp0_zero   = rsp0_valid && zero_q;
  assign rsp1_zero   = rsp1_valid && zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven check of the ALU arbiter with a small ALU model
// attached to its ALU port, plus hand-written sequences for back-pressure and reset.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_op;
  logic        rsp0_valid, rsp0_ready, rsp0_zero;
  logic [31:0] rsp0_result;
  logic        rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        busy;

  int errorCount = 0;
  int checkCount = 0;

  alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: add, sub, and, or, signed less-than, all ones otherwise
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'hFFFF_FFFF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [2:0]  op0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [2:0]  op1;
    logic        rr0;
    logic        rr1;
    logic        eRdy0;
    logic        eRdy1;
    logic        eVal0;
    logic [31:0] eRes0;
    logic        eZ0;
    logic        eVal1;
    logic [31:0] eRes1;
    logic        eZ1;
    logic        eBusy;
    logic        chkAlu;
    logic [31:0] eAluA;
    logic [31:0] eAluB;
    logic [2:0]  eAluOp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(
    input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
    input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
    input logic rr0, input logic rr1,
    input logic eRdy0, input logic eRdy1,
    input logic eVal0, input logic [31:0] eRes0, input logic eZ0,
    input logic eVal1, input logic [31:0] eRes1, input logic eZ1,
    input logic eBusy, input logic chkAlu,
    input logic [31:0] eAluA, input logic [31:0] eAluB, input logic [2:0] eAluOp);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1;
    v.rr0 = rr0; v.rr1 = rr1;
    v.eRdy0 = eRdy0; v.eRdy1 = eRdy1;
    v.eVal0 = eVal0; v.eRes0 = eRes0; v.eZ0 = eZ0;
    v.eVal1 = eVal1; v.eRes1 = eRes1; v.eZ1 = eZ1;
    v.eBusy = eBusy; v.chkAlu = chkAlu;
    v.eAluA = eAluA; v.eAluB = eAluB; v.eAluOp = eAluOp;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
    rsp0_ready = v.rr0; rsp1_ready = v.rr1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkVal($sformatf("v%0d.req0_ready", idx), 32'(req0_ready), 32'(v.eRdy0));
    checkVal($sformatf("v%0d.req1_ready", idx), 32'(req1_ready), 32'(v.eRdy1));
    checkVal($sformatf("v%0d.rsp0_valid", idx), 32'(rsp0_valid), 32'(v.eVal0));
    checkVal($sformatf("v%0d.rsp0_result", idx), rsp0_result, v.eRes0);
    checkVal($sformatf("v%0d.rsp0_zero", idx), 32'(rsp0_zero), 32'(v.eZ0));
    checkVal($sformatf("v%0d.rsp1_valid", idx), 32'(rsp1_valid), 32'(v.eVal1));
    checkVal($sformatf("v%0d.rsp1_result", idx), rsp1_result, v.eRes1);
    checkVal($sformatf("v%0d.rsp1_zero", idx), 32'(rsp1_zero), 32'(v.eZ1));
    checkVal($sformatf("v%0d.busy", idx), 32'(busy), 32'(v.eBusy));
    if (v.chkAlu) begin
      checkVal($sformatf("v%0d.alu_a", idx), alu_a, v.eAluA);
      checkVal($sformatf("v%0d.alu_b", idx), alu_b, v.eAluB);
      checkVal($sformatf("v%0d.alu_op", idx), 32'(alu_op), 32'(v.eAluOp));
    end
  endtask

  task automatic setIdle();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  // Main sequence: reset, vector table, back-pressure hold, reset during EXEC
  initial begin
    setIdle();
    rst_n = 1'b0;
    #1;
    req0_valid = 1'b1;
    #1;
    checkVal("reset.req0_ready", 32'(req0_ready), 32'd0);
    checkVal("reset.busy", 32'(busy), 32'd0);
    checkVal("reset.rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkVal("reset.rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkVal("reset.alu_a", alu_a, 32'd0);
    checkVal("reset.rsp0_result", rsp0_result, 32'd0);
    setIdle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // add: 5+3=8, two edges to rsp0_valid, released immediately
    vecs.push_back(mkVec(1,5,3,0, 0,0,0,0, 1,0, 1,0, 0,0,0, 0,0,0, 0, 0,0,0,0));
    vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 1,0, 0,0, 0,0,0, 0,0,0, 1, 1,5,3,0));
    vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 1,0, 0,0, 1,8,0, 0,0,0, 1, 0,0,0,0));
    vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0, 0,0,0,0));
    // sub on requester 1: 7-7=0 sets zero, rsp0 stays quiet
    vecs.push_back(mkVec(0,0,0,0, 1,7,7,1, 0,1, 0,1, 0,0,0, 0,0,0, 0, 0,0,0,0));
    vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 0,1, 0,0, 0,0,0, 0,0,0, 1, 1,7,7,1));
    vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 0,1, 0,0, 0,0,0, 1,0,1, 1, 0,0,0,0));
    // both valid continuously: grants 0,1,0,1, one accept every 3 cycles
    vecs.push_back(mkVec(1,10,1,0, 1,20,4,1, 1,1, 1,0, 0,0,0, 0,0,0, 0, 0,0,0,0));
    vecs.push_back(mkVec(1,10,1,0, 1,20,4,1, 1,1, 0,0, 0,0,0, 0,0,0, 1, 1,10,1,0));
    vecs.push_back(mkVec(1,10,1,0, 1,20,4,1, 1,1, 0,0, 1,11,0, 0,0,0, 1, 0,0,0,0));
    vecs.push_back(mkVec(1,10,1,0, 1,20,4,1, 1,1, 0,1, 0,0,0, 0,0,0, 0, 0,0,0,0));
    vecs.push_back(mkVec(1,10,1,0, 1,20,4,1, 1,1, 0,0, 0,0,0, 0,0,0, 1, 1,20,4,1));
    vecs.push_back(mkVec(1,10,1,0, 1,20,4,1, 1,1, 0,0, 0,0,0, 1,16,0, 1, 0,0,0,0));
    vecs.push_back(mkVec(1,10,1,0, 1,20,4,1, 1,1, 1,0, 0,0,0, 0,0,0, 0, 0,0,0,0));
    vecs.push_back(mkVec(1,10,1,0, 1,20,4,1, 1,1, 0,0, 0,0,0, 0,0,0, 1, 1,10,1,0));
    vecs.push_back(mkVec(1,10,1,0, 1,20,4,1, 1,1, 0,0, 1,11,0, 0,0,0, 1, 0,0,0,0));
    vecs.push_back(mkVec(1,10,1,0, 1,20,4,1, 1,1, 0,1, 0,0,0, 0,0,0, 0, 0,0,0,0));
    vecs.push_back(mkVec(1,10,1,0, 1,20,4,1, 1,1, 0,0, 0,0,0, 0,0,0, 1, 1,20,4,1));
    vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 1,1, 0,0, 0,0,0, 1,16,0, 1, 0,0,0,0));
    vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 1,1, 0,0, 0,0,0, 0,0,0, 0, 0,0,0,0));
    // slt 3<9 gives 1, then undefined code 111 gives all ones with zero clear
    vecs.push_back(mkVec(1,3,9,4, 0,0,0,0, 1,0, 1,0, 0,0,0, 0,0,0, 0, 0,0,0,0));
    vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 1,0, 0,0, 0,0,0, 0,0,0, 1, 1,3,9,4));
    vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 1,0, 0,0, 1,1,0, 0,0,0, 1, 0,0,0,0));
    vecs.push_back(mkVec(1,3,9,7, 0,0,0,0, 1,0, 1,0, 0,0,0, 0,0,0, 0, 0,0,0,0));
    vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 1,0, 0,0, 0,0,0, 0,0,0, 1, 1,3,9,7));
    vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 1,0, 0,0, 1,32'hFFFF_FFFF,0, 0,0,0, 1, 0,0,0,0));
    vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0, 0,0,0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
    end

    // and F0F0&FF00 held under back-pressure while requester 1 waits
    @(negedge clk);
    setIdle();
    req0_valid = 1'b1; req0_a = 32'hF0F0; req0_b = 32'hFF00; req0_op = 3'b010;
    #1;
    checkVal("hold.accept.req0_ready", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 3'b000;
    #1;
    checkVal("hold.exec.req1_ready", 32'(req1_ready), 32'd0);
    checkVal("hold.exec.alu_a", alu_a, 32'hF0F0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checkVal($sformatf("hold%0d.rsp0_valid", k), 32'(rsp0_valid), 32'd1);
      checkVal($sformatf("hold%0d.rsp0_result", k), rsp0_result, 32'hF000);
      checkVal($sformatf("hold%0d.req1_ready", k), 32'(req1_ready), 32'd0);
      checkVal($sformatf("hold%0d.rsp1_valid", k), 32'(rsp1_valid), 32'd0);
    end
    @(negedge clk);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    checkVal("hold.release.rsp0_result", rsp0_result, 32'hF000);
    @(negedge clk);
    #1;
    checkVal("hold.after.rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkVal("hold.after.req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    checkVal("hold.req1.rsp1_result", rsp1_result, 32'd2);

    // reset while requester 1 is in EXEC with rr pointing at requester 0
    @(negedge clk);
    setIdle();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4; req0_op = 3'b000;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #1;
    checkVal("rst.pre.rsp0_result", rsp0_result, 32'd8);
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd2; req1_op = 3'b001;
    #1;
    checkVal("rst.pre.req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    checkVal("rst.exec.busy", 32'(busy), 32'd1);
    checkVal("rst.exec.alu_a", alu_a, 32'd7);
    #1;
    rst_n = 1'b0;
    #1;
    checkVal("rst.async.busy", 32'(busy), 32'd0);
    checkVal("rst.async.alu_a", alu_a, 32'd0);
    checkVal("rst.async.alu_b", alu_b, 32'd0);
    checkVal("rst.async.alu_op", 32'(alu_op), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkVal($sformatf("rst%0d.rsp1_valid", k), 32'(rsp1_valid), 32'd0);
      checkVal($sformatf("rst%0d.rsp1_result", k), rsp1_result, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = 3'b001;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd1; req1_op = 3'b000;
    #1;
    checkVal("rst.after.req0_ready", 32'(req0_ready), 32'd1);
    checkVal("rst.after.req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    setIdle();
    rsp0_ready = 1'b1;
    @(negedge clk);
    #1;
    checkVal("rst.after.rsp0_valid", 32'(rsp0_valid), 32'd1);
    checkVal("rst.after.rsp0_zero", 32'(rsp0_zero), 32'd1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
